mmio_adder_array: RTL
=====================

# mmio_adder_array

Parametrised CCI-P MMIO accelerator: NUM_CH independent operand/result channels, WIDTH-bit operands, software-selectable add / subtract / accumulate mode. One shared arithmetic unit processes the channels sequentially after a software start command. Busy/done/overflow status is readable over MMIO. Sits directly under the platform shim as the AFU top and serves the standard DFH/AFU-ID registers alongside the application registers.

## Interface
- NUM_CH, default 4: number of channels; legal range 1..16.
- WIDTH, default 16: operand width in bits; legal range 1..63.
- clock  input  1  CCI-P clock; all state is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  t_if_ccip_Rx  CCI-P receive channel; only c0 MMIO requests are used.
- tx  output  t_if_ccip_Tx  CCI-P transmit channel; only c2 MMIO read responses are driven.

## Operation
- MMIO request header: rx.c0.hdr cast to t_ccip_c0_ReqMmioHdr. Addresses are 16-bit DWORD addresses. Write data is rx.c0.data.
- Read map:
  - 0x0000: AFU DFH = type 4'b0001, EOL=1, all other fields 0.
  - 0x0002 / 0x0004: AFU_ACCEL_UUID [63:0] / [127:64].
  - 0x0006, 0x0008: 0.
- CTRL (0x0010), write:
  - bits[2:1] = mode: 00 add, 01 sub, 10 accumulate; 11 is stored but treated as add.
  - bit0 = start.
  - Read returns {61'b0, mode, 1'b0}.
- STATUS (0x0012), read-only: bit0 busy, bit1 done, bit2 ovf; other bits 0.
- Channel i registers, base 0x0020 + 8*i:
  - +0 OPA, read/write: stores D[WIDTH-1:0].
  - +2 OPB, read/write: stores D[WIDTH-1:0].
  - +4 RESULT, read-only: WIDTH+1 bits, zero-extended to 64.
- Unmapped reads return 0; unmapped writes are ignored.
- Engine FSM:
  - IDLE: write to CTRL with bit0=1 latches mode, clears done and ovf, sets idx=0 and goes to RUN.
  - RUN: each cycle computes channel idx and increments idx. After idx=NUM_CH-1 it goes to IDLE and sets done=1.
  - busy = (state==RUN).
- Arithmetic, per channel:
  - add: RESULT = OPA + OPB. Bit WIDTH is the carry.
  - sub: RESULT = {OPA<OPB, (OPA-OPB) mod 2^WIDTH}. Bit WIDTH is the borrow.
  - accumulate: RESULT = RESULT[WIDTH-1:0] + OPA. Bit WIDTH is that step's carry; OPB is unused.
  - ovf is set if any channel's RESULT[WIDTH] is 1 in the current run. It is sticky until the next start.
- Boundary rules:
  - While busy, start writes and writes to OPA/OPB are dropped; CTRL.mode is not changed.
  - Reads are always served, including while busy.
  - Accumulate wraps mod 2^WIDTH per step.

## Timing
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - All OPA/OPB/RESULT/mode/done/ovf are 0.
  - tx.c0.valid, tx.c1.valid and tx.c2.mmioRdValid are 0; tx.c0/c1/c2 hdr and tx.c2.data are 0.
  - Assertion mid-RUN aborts the run, and results go to 0.
- Read response: rx.c0.mmioRdValid in cycle T gives tx.c2.mmioRdValid=1 for exactly cycle T+1, with tx.c2.hdr.tid = request tid and data as sampled at T.
- Start write in cycle T:
  - busy=1 from T+1.
  - Channel k RESULT is visible from T+2+k.
  - busy=0 and done=1 from T+1+NUM_CH.
- A read of RESULT_k in the same cycle as its update returns the old value.
- Back-to-back reads on consecutive cycles give one response per cycle.

## Test plan
- Reset, then read 0x0000, 0x0002, 0x0004 and 0x0012 -> DFH 0x1000_0100_0000_0000, UUID halves, STATUS 0. Each response arrives 1 cycle after its request, with tid echoed.
- Add (WIDTH=16): ch0 OPA=0xFFFF, OPB=0x0001; ch3 OPA=0x1234, OPB=0x0001; start -> ch0 RESULT 0x10000, ch3 RESULT 0x01235, STATUS 0b110. done is set exactly NUM_CH+1 cycles after the start write.
- Sub: ch1 OPA=5, OPB=7, mode 01 -> RESULT 0x1FFFE, ovf=1. Rerun with OPA=7, OPB=5 -> RESULT 0x00002, ovf=0.
- Accumulate: ch2 OPA=0x8000, three starts in mode 10 -> RESULT 0x08000, then 0x10000, then 0x08000.
- While busy, write OPA=0xAAAA and a start -> both dropped; RESULTs match the original run and a STATUS read during the run shows busy=1.
- Assert reset_n mid-RUN -> busy=0, done=0, all RESULT=0 immediately; an unmapped read of 0x0100 returns 0.

Source files
------------

// File: rtl/ccip_if_pkg.sv
// Subset of the CCI-P channel types used by the MMIO-only AFU.
// It carries just the fields this block reads or drives.
package ccip_if_pkg;

    typedef logic [27:0] t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

// File: rtl/mmio_adder_array.sv
// MMIO-controlled adder array: NUM_CH operand/result channels served by one
// shared add/sub/accumulate unit that walks the channels after a start write.
module mmio_adder_array
    import ccip_if_pkg::*;
#(
    parameter int           NUM_CH = 4,
    parameter int           WIDTH  = 16,
    parameter logic [127:0] AFU_ID = 128'h3f1a6c2e_9b044d7e_8a550c21_7e9db0f3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  t_if_ccip_Rx rx,
    output t_if_ccip_Tx tx
);

    localparam int          IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] ADDR_DFH    = 16'h0000;
    localparam logic [15:0] ADDR_UUID_L = 16'h0002;
    localparam logic [15:0] ADDR_UUID_H = 16'h0004;
    localparam logic [15:0] ADDR_CTRL   = 16'h0010;
    localparam logic [15:0] ADDR_STATUS = 16'h0012;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg, state_next;
    logic                 busy, last_step;
    logic [IDX_W-1:0]     idx_reg;
    logic [1:0]           mode_reg;
    logic                 done_reg, ovf_reg;
    logic                 rd_valid_reg;
    logic [8:0]           rd_tid_reg;
    logic [63:0]          rd_data_reg, rd_data;
    logic [WIDTH:0]       calc;
    logic [WIDTH-1:0]     opa_arr [NUM_CH];
    logic [WIDTH-1:0]     opb_arr [NUM_CH];
    logic [WIDTH:0]       res_arr [NUM_CH];

    t_ccip_c0_ReqMmioHdr  req_hdr;
    logic [15:0]          addr;
    logic                 wr_en, rd_en, start_cmd;
    logic [WIDTH-1:0]     wr_data;
    logic                 unused_bits;

    assign req_hdr     = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
    assign addr        = req_hdr.address;
    assign wr_en       = rx.c0.mmioWrValid;
    assign rd_en       = rx.c0.mmioRdValid;
    assign wr_data     = rx.c0.data[WIDTH-1:0];
    assign start_cmd   = wr_en && (addr == ADDR_CTRL) && rx.c0.data[0] && !busy;
    assign unused_bits = ^{rx, req_hdr};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_cmd) state_next = RUN;
            RUN:     if (idx_reg == IDX_W'(NUM_CH - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg == RUN);
        last_step = busy && (idx_reg == IDX_W'(NUM_CH - 1));
    end

    // Mode 11 falls through to add; the sub borrow is simply a < b.
    always_comb begin
        case (mode_reg)
            2'b01:   calc = {opa_arr[idx_reg] < opb_arr[idx_reg],
                             opa_arr[idx_reg] - opb_arr[idx_reg]};
            2'b10:   calc = {1'b0, res_arr[idx_reg][WIDTH-1:0]} + {1'b0, opa_arr[idx_reg]};
            default: calc = {1'b0, opa_arr[idx_reg]} + {1'b0, opb_arr[idx_reg]};
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg  <= '0;
            mode_reg <= 2'b00;
            done_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            if (wr_en && (addr == ADDR_CTRL) && !busy) begin
                mode_reg <= rx.c0.data[2:1];
            end
            if (start_cmd) begin
                idx_reg  <= '0;
                done_reg <= 1'b0;
                ovf_reg  <= 1'b0;
            end else if (busy) begin
                idx_reg <= idx_reg + IDX_W'(1);
                if (calc[WIDTH]) ovf_reg <= 1'b1;
                if (last_step) done_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [15:0] BASE = 16'(32 + 8 * gi);
        logic [WIDTH-1:0] opa_reg, opb_reg;
        logic [WIDTH:0]   res_reg;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                opa_reg <= '0;
                opb_reg <= '0;
                res_reg <= '0;
            end else begin
                if (wr_en && !busy && (addr == BASE))          opa_reg <= wr_data;
                if (wr_en && !busy && (addr == BASE + 16'd2))  opb_reg <= wr_data;
                if (busy && (idx_reg == IDX_W'(gi)))           res_reg <= calc;
            end
        end

        assign opa_arr[gi] = opa_reg;
        assign opb_arr[gi] = opb_reg;
        assign res_arr[gi] = res_reg;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DFH:    rd_data = 64'h1000_0100_0000_0000;
            ADDR_UUID_L: rd_data = AFU_ID[63:0];
            ADDR_UUID_H: rd_data = AFU_ID[127:64];
            ADDR_CTRL:   rd_data = {61'b0, mode_reg, 1'b0};
            ADDR_STATUS: rd_data = {61'b0, ovf_reg, done_reg, busy};
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr == 16'(32 + 8 * i))     rd_data[WIDTH-1:0] = opa_arr[i];
                    if (addr == 16'(34 + 8 * i))     rd_data[WIDTH-1:0] = opb_arr[i];
                    if (addr == 16'(36 + 8 * i))     rd_data[WIDTH:0]   = res_arr[i];
                end
            end
        endcase
    end

    // Read data is captured in the request cycle, so a same-cycle result
    // update is not yet visible to that read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rd_tid_reg   <= '0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_tid_reg  <= req_hdr.tid;
                rd_data_reg <= rd_data;
            end
        end
    end

    always_comb begin
        tx                 = '0;
        tx.c2.mmioRdValid  = rd_valid_reg;
        tx.c2.hdr.tid      = rd_tid_reg;
        tx.c2.data         = rd_data_reg;
    end

endmodule
